ext_nand_page_read_seq: RTL

//  Sequences one external-NAND page read: drives CMD 0x00, 5 address cycles, CMD 0x30,

---
 rtl/ext_nand_page_read_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ext_nand_page_read_seq.sv
// ext_nand_page_read_seq: sequences one NAND page read (CMD 00, 5 address bytes, CMD 30, R/B# wait, reader enable); define NAND_RB_TIMEOUT_EN for the R/B# wait timeout
module ext_nand_page_read_seq #(
   parameter int WE_LOW_CYC  = 2,
   parameter int WE_HIGH_CYC = 2,
   parameter int TWB_CYC     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic [23:0] ROW_ADDR,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic        CE_N,
   output logic        CLE,
   output logic        ALE,
   output logic        WE_N,
   output logic [7:0]  IO_OUT,
   output logic        IO_OE,
   input  logic        RB,
   output logic        RD_ENA,
   input  logic        RD_COMPLT
);
   localparam int BC = WE_LOW_CYC + WE_HIGH_CYC;
   localparam int M1 = (BC > TWB_CYC) ? BC : TWB_CYC;
   localparam int M2 = (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
   localparam int CW = $clog2(M2 + 1);
   typedef enum logic [2:0] {IDLE, CMD0, ADDR, CMD1, TWB, WAIT_RDY, READ, FIN} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0] idx, idx_nxt;
   logic [23:0] row;
   logic [1:0] rb_q;
   logic byte_st, byte_end;
   // two-flop synchroniser for the asynchronous R/B# line
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) rb_q <= 2'b00;
      else rb_q <= {rb_q[0], RB};
   // state, shared cycle counter, address byte index and latched row
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         if (state == IDLE && START) row <= ROW_ADDR;
      end
`ifdef NAND_RB_TIMEOUT_EN
   logic to_hit, err_q;
   assign to_hit = state == WAIT_RDY && !rb_q[1] && cnt == CW'(TIMEOUT_CYC - 1);
   // timeout flag, cleared by the next accepted request
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) err_q <= 1'b0;
      else if (state == IDLE && START) err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif
   assign byte_st  = state inside {CMD0, ADDR, CMD1};
   assign byte_end = cnt == CW'(BC - 1);
   // next state; the counter reloads on every state entry and at each byte boundary
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (START) state_nxt = CMD0;
         end
         CMD0: if (byte_end) begin
            cnt_nxt   = '0;
            state_nxt = ADDR;
         end
         ADDR: if (byte_end) begin
            cnt_nxt = '0;
            idx_nxt = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            if (idx == 3'd4) state_nxt = CMD1;
         end
         CMD1: if (byte_end) begin
            cnt_nxt   = '0;
            state_nxt = TWB;
         end
         TWB: if (cnt == CW'(TWB_CYC - 1)) begin
            cnt_nxt   = '0;
            state_nxt = WAIT_RDY;
         end
         WAIT_RDY: begin
`ifdef NAND_RB_TIMEOUT_EN
            if (rb_q[1] || to_hit) begin
               cnt_nxt   = '0;
               state_nxt = rb_q[1] ? READ : FIN;
            end
`else
            cnt_nxt = '0;
            if (rb_q[1]) state_nxt = READ;
`endif
         end
         READ: begin
            cnt_nxt = '0;
            if (RD_COMPLT) state_nxt = FIN;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end
   assign BUSY   = state != IDLE;
   assign CE_N   = state == IDLE;
   assign DONE   = state == FIN;
   assign CLE    = state == CMD0 || state == CMD1;
   assign ALE    = state == ADDR;
   assign IO_OE  = byte_st;
   assign WE_N   = !(byte_st && cnt < CW'(WE_LOW_CYC));
   assign RD_ENA = state == READ;
   assign IO_OUT = (state == CMD1) ? 8'h30 :
                   (state != ADDR) ? 8'h00 :
                   (idx == 3'd2)   ? row[7:0] :
                   (idx == 3'd3)   ? row[15:8] :
                   (idx == 3'd4)   ? row[23:16] : 8'h00;
endmodule
